// File: rtl/hood_timer_pkg.sv
// Shared definitions for the range-hood timer blocks: the mode codes driven by
// the top-level FSM, the display separator digit, the countdown state encoding,
// and helpers that split seconds into mm:ss and two-digit values into BCD.
package hood_timer_pkg;

  localparam int unsigned MODE_W = 3;
  localparam int unsigned HOUR_W = 7;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned SEC_W  = 6;
  localparam int unsigned CDM_W  = 7;
  localparam int unsigned USES_W = 8;

  localparam logic [MODE_W-1:0] MODE_STANDBY   = 3'd0;
  localparam logic [MODE_W-1:0] MODE_GEAR1     = 3'd1;
  localparam logic [MODE_W-1:0] MODE_GEAR2     = 3'd2;
  localparam logic [MODE_W-1:0] MODE_HURRICANE = 3'd3;
  localparam logic [MODE_W-1:0] MODE_SELFCLEAN = 3'd4;

  localparam logic [3:0] SEP_DIGIT = 4'hF;

  typedef enum logic [2:0] {
    CD_IDLE   = 3'd0,
    CD_HURR   = 3'd1,
    CD_CLEAN  = 3'd2,
    CD_EXPIRE = 3'd3,
    CD_LOCKED = 3'd4
  } cd_state_e;

  // Countdown value as minutes and seconds
  typedef struct packed {
    logic [CDM_W-1:0] mm;
    logic [SEC_W-1:0] ss;
  } mmss_t;

  // Split a duration in seconds into mm:ss
  function automatic mmss_t sec_to_mmss(input int unsigned n);
    mmss_t r;
    r.mm = CDM_W'(n / 60);
    r.ss = SEC_W'(n % 60);
    return r;
  endfunction

  // Two BCD digits of a 0..99 value
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

endpackage

// File: rtl/mmss_down_counter.sv
// mm:ss down counter shared by the hurricane and self-clean countdowns.
// Ports: load/load_val preset the count (priority over enable); enable
// decrements one second per edge and stops at 00:00; mm/ss/zero report it.
module mmss_down_counter
  import hood_timer_pkg::*;
(
  input  logic             clk_1hz,
  input  logic             rst,
  input  logic             load,
  input  mmss_t            load_val,
  input  logic             enable,
  output logic [CDM_W-1:0] mm,
  output logic [SEC_W-1:0] ss,
  output logic             zero
);

  logic [CDM_W-1:0] mm_q, mm_d;
  logic [SEC_W-1:0] ss_q, ss_d;
  logic             zero_c;

  assign zero_c = (mm_q == '0) && (ss_q == '0);

  // Load, or decrement with a borrow from minutes when seconds wrap
  always_comb begin
    mm_d = mm_q;
    ss_d = ss_q;
    if (load) begin
      mm_d = load_val.mm;
      ss_d = load_val.ss;
    end else if (enable && !zero_c) begin
      if (ss_q == '0) begin
        ss_d = SEC_W'(59);
        mm_d = mm_q - CDM_W'(1);
      end else begin
        ss_d = ss_q - SEC_W'(1);
      end
    end
  end

  always_ff @(posedge clk_1hz or negedge rst) begin
    if (!rst) begin
      mm_q <= '0;
      ss_q <= '0;
    end else begin
      mm_q <= mm_d;
      ss_q <= ss_d;
    end
  end

  assign mm   = mm_q;
  assign ss   = ss_q;
  assign zero = zero_c;

endmodule

// File: rtl/hood_runtime_tracker.sv
// Runtime and countdown engine for the range-hood controller (1 Hz clock).
// Inputs: power_on, mode_state (from the top-level FSM), hand_clean and
// menu_cancel (debounced levels). Outputs: accumulated run time cum_h/m/s,
// countdown cd_m/cd_s with countdown_active, a one-cycle return_req with the
// fallback mode return_state, hurricane availability/uses_left, the
// need_clean reminder and a BCD display word (hh F mm F ss).
module hood_runtime_tracker
  import hood_timer_pkg::*;
#(
  parameter int unsigned HURRICANE_SEC    = 60,
  parameter int unsigned SELF_CLEAN_SEC   = 180,
  parameter int unsigned HURRICANE_USES   = 1,
  parameter int unsigned CLEAN_THRESH_SEC = 36000,
  parameter int unsigned MAX_HOURS        = 99
) (
  input  logic              clk_1hz,
  input  logic              rst,
  input  logic              power_on,
  input  logic [MODE_W-1:0] mode_state,
  input  logic              hand_clean,
  input  logic              menu_cancel,
  output logic [HOUR_W-1:0] cum_h,
  output logic [MIN_W-1:0]  cum_m,
  output logic [SEC_W-1:0]  cum_s,
  output logic [CDM_W-1:0]  cd_m,
  output logic [SEC_W-1:0]  cd_s,
  output logic              countdown_active,
  output logic              return_req,
  output logic [MODE_W-1:0] return_state,
  output logic              hurricane_avail,
  output logic [USES_W-1:0] uses_left,
  output logic              need_clean,
  output logic [31:0]       display_data
);

  localparam bit    UNLIMITED  = (HURRICANE_USES == 0);
  localparam mmss_t HURR_LOAD  = sec_to_mmss(HURRICANE_SEC);
  localparam mmss_t CLEAN_LOAD = sec_to_mmss(SELF_CLEAN_SEC);

  cd_state_e         state_q, state_d;
  logic [USES_W-1:0] uses_q, uses_d;
  logic              cancel_q, cancel_d;
  logic              return_req_q, return_req_d;
  logic [MODE_W-1:0] return_state_q, return_state_d;
  logic [HOUR_W-1:0] cum_h_q, cum_h_d;
  logic [MIN_W-1:0]  cum_m_q, cum_m_d;
  logic [SEC_W-1:0]  cum_s_q, cum_s_d;
  logic              need_clean_q, need_clean_d;

  logic              cd_load, cd_enable, cd_zero, sc_clear;
  mmss_t             cd_load_val;
  logic [CDM_W-1:0]  cd_mm;
  logic [SEC_W-1:0]  cd_ss;
  logic              hurr_avail_c, active_c;

  assign hurr_avail_c = (state_q == CD_IDLE) && (UNLIMITED || (uses_q != '0));
  assign active_c     = (state_q == CD_HURR) || (state_q == CD_CLEAN);

  mmss_down_counter u_cd (
    .clk_1hz  (clk_1hz),
    .rst      (rst),
    .load     (cd_load),
    .load_val (cd_load_val),
    .enable   (cd_enable),
    .mm       (cd_mm),
    .ss       (cd_ss),
    .zero     (cd_zero)
  );

  // Countdown FSM: start, run, abort (load 0), expire and lock-out
  always_comb begin
    state_d        = state_q;
    uses_d         = uses_q;
    cancel_d       = cancel_q;
    return_req_d   = 1'b0;
    return_state_d = return_state_q;
    cd_load        = 1'b0;
    cd_load_val    = '0;
    cd_enable      = 1'b0;
    sc_clear       = 1'b0;
    case (state_q)
      CD_IDLE: begin
        if ((mode_state == MODE_HURRICANE) && hurr_avail_c) begin
          cd_load     = 1'b1;
          cd_load_val = HURR_LOAD;
          cancel_d    = 1'b0;
          state_d     = CD_HURR;
          if (!UNLIMITED) uses_d = uses_q - USES_W'(1);
        end else if (mode_state == MODE_SELFCLEAN) begin
          cd_load     = 1'b1;
          cd_load_val = CLEAN_LOAD;
          state_d     = CD_CLEAN;
        end
      end
      CD_LOCKED: begin
        if (mode_state == MODE_SELFCLEAN) begin
          cd_load     = 1'b1;
          cd_load_val = CLEAN_LOAD;
          state_d     = CD_CLEAN;
        end
      end
      CD_HURR: begin
        if (mode_state != MODE_HURRICANE) begin
          cd_load = 1'b1;
          state_d = CD_IDLE;
        end else begin
          if (menu_cancel) cancel_d = 1'b1;
          if (cd_zero) begin
            state_d        = CD_EXPIRE;
            return_req_d   = 1'b1;
            return_state_d = cancel_q ? MODE_STANDBY : MODE_GEAR2;
          end else begin
            cd_enable = 1'b1;
          end
        end
      end
      CD_CLEAN: begin
        if (mode_state != MODE_SELFCLEAN) begin
          cd_load = 1'b1;
          state_d = CD_IDLE;
        end else if (cd_zero) begin
          state_d        = CD_EXPIRE;
          return_req_d   = 1'b1;
          return_state_d = MODE_STANDBY;
          sc_clear       = 1'b1;
        end else begin
          cd_enable = 1'b1;
        end
      end
      CD_EXPIRE: begin
        // Return to idle only after mode 3 is released, so a held request cannot retrigger
        if (!UNLIMITED && (uses_q == '0)) state_d = CD_LOCKED;
        else if (mode_state != MODE_HURRICANE) state_d = CD_IDLE;
      end
      default: state_d = CD_IDLE;
    endcase
  end

  // Run-time accumulator with clear priority and saturation at MAX_HOURS:59:59
  always_comb begin
    logic run, at_max;
    cum_h_d = cum_h_q;
    cum_m_d = cum_m_q;
    cum_s_d = cum_s_q;
    run     = power_on && ((mode_state == MODE_GEAR1) || (mode_state == MODE_GEAR2) ||
                           (mode_state == MODE_HURRICANE));
    at_max  = (cum_h_q == HOUR_W'(MAX_HOURS)) && (cum_m_q == MIN_W'(59)) &&
              (cum_s_q == SEC_W'(59));
    if (hand_clean || sc_clear) begin
      cum_h_d = '0;
      cum_m_d = '0;
      cum_s_d = '0;
    end else if (run && !at_max) begin
      if (cum_s_q == SEC_W'(59)) begin
        cum_s_d = '0;
        if (cum_m_q == MIN_W'(59)) begin
          cum_m_d = '0;
          cum_h_d = cum_h_q + HOUR_W'(1);
        end else begin
          cum_m_d = cum_m_q + MIN_W'(1);
        end
      end else begin
        cum_s_d = cum_s_q + SEC_W'(1);
      end
    end
  end

  // Reminder follows the counters one edge late
  always_comb begin
    logic [31:0] total;
    total        = 32'(cum_h_q) * 32'd3600 + 32'(cum_m_q) * 32'd60 + 32'(cum_s_q);
    need_clean_d = power_on && (total >= 32'(CLEAN_THRESH_SEC));
  end

  always_ff @(posedge clk_1hz or negedge rst) begin
    if (!rst) begin
      state_q        <= CD_IDLE;
      uses_q         <= UNLIMITED ? '0 : USES_W'(HURRICANE_USES);
      cancel_q       <= 1'b0;
      return_req_q   <= 1'b0;
      return_state_q <= MODE_STANDBY;
      cum_h_q        <= '0;
      cum_m_q        <= '0;
      cum_s_q        <= '0;
      need_clean_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      uses_q         <= uses_d;
      cancel_q       <= cancel_d;
      return_req_q   <= return_req_d;
      return_state_q <= return_state_d;
      cum_h_q        <= cum_h_d;
      cum_m_q        <= cum_m_d;
      cum_s_q        <= cum_s_d;
      need_clean_q   <= need_clean_d;
    end
  end

  // Display shows the countdown while running, otherwise the accumulator
  always_comb begin
    logic [6:0] dh, dm, ds;
    if (active_c) begin
      dh = '0;
      dm = cd_mm;
      ds = 7'(cd_ss);
    end else begin
      dh = cum_h_q;
      dm = 7'(cum_m_q);
      ds = 7'(cum_s_q);
    end
    display_data = {to_bcd(dh), SEP_DIGIT, to_bcd(dm), SEP_DIGIT, to_bcd(ds)};
  end

  assign cum_h            = cum_h_q;
  assign cum_m            = cum_m_q;
  assign cum_s            = cum_s_q;
  assign cd_m             = cd_mm;
  assign cd_s             = cd_ss;
  assign countdown_active = active_c;
  assign return_req       = return_req_q;
  assign return_state     = return_state_q;
  assign hurricane_avail  = hurr_avail_c;
  assign uses_left        = uses_q;
  assign need_clean       = need_clean_q;

endmodule

// File: tb/tb_hood_runtime_tracker.sv
// Directed bench for hood_runtime_tracker. Three instances share the stimulus:
// u_a (5 s hurricane, 1 use, 3 s self-clean, 10 s clean threshold),
// u_b (2 uses) and u_c (MAX_HOURS=0, default threshold).
module tb_hood_runtime_tracker;

  logic       clk_1hz = 1'b0;
  logic       rst = 1'b1;
  logic       power_on = 1'b0;
  logic [2:0] mode_state = 3'd0;
  logic       hand_clean = 1'b0;
  logic       menu_cancel = 1'b0;

  logic [6:0] a_h, b_h, c_h, a_cdm, b_cdm, c_cdm;
  logic [5:0] a_m, b_m, c_m, a_s, b_s, c_s, a_cds, b_cds, c_cds;
  logic       a_act, b_act, c_act, a_req, b_req, c_req;
  logic [2:0] a_rs, b_rs, c_rs;
  logic       a_av, b_av, c_av, a_nc, b_nc, c_nc;
  logic [7:0] a_ul, b_ul, c_ul;
  logic [31:0] a_disp, b_disp, c_disp;

  int total = 0;
  int bad = 0;

  always #5 clk_1hz = ~clk_1hz;

  hood_runtime_tracker #(.HURRICANE_SEC(5), .SELF_CLEAN_SEC(3), .HURRICANE_USES(1),
                         .CLEAN_THRESH_SEC(10), .MAX_HOURS(99)) u_a (
    .clk_1hz(clk_1hz), .rst(rst), .power_on(power_on), .mode_state(mode_state),
    .hand_clean(hand_clean), .menu_cancel(menu_cancel),
    .cum_h(a_h), .cum_m(a_m), .cum_s(a_s), .cd_m(a_cdm), .cd_s(a_cds),
    .countdown_active(a_act), .return_req(a_req), .return_state(a_rs),
    .hurricane_avail(a_av), .uses_left(a_ul), .need_clean(a_nc), .display_data(a_disp));

  hood_runtime_tracker #(.HURRICANE_SEC(5), .SELF_CLEAN_SEC(3), .HURRICANE_USES(2),
                         .CLEAN_THRESH_SEC(36000), .MAX_HOURS(99)) u_b (
    .clk_1hz(clk_1hz), .rst(rst), .power_on(power_on), .mode_state(mode_state),
    .hand_clean(hand_clean), .menu_cancel(menu_cancel),
    .cum_h(b_h), .cum_m(b_m), .cum_s(b_s), .cd_m(b_cdm), .cd_s(b_cds),
    .countdown_active(b_act), .return_req(b_req), .return_state(b_rs),
    .hurricane_avail(b_av), .uses_left(b_ul), .need_clean(b_nc), .display_data(b_disp));

  hood_runtime_tracker #(.HURRICANE_SEC(60), .SELF_CLEAN_SEC(180), .HURRICANE_USES(1),
                         .CLEAN_THRESH_SEC(36000), .MAX_HOURS(0)) u_c (
    .clk_1hz(clk_1hz), .rst(rst), .power_on(power_on), .mode_state(mode_state),
    .hand_clean(hand_clean), .menu_cancel(menu_cancel),
    .cum_h(c_h), .cum_m(c_m), .cum_s(c_s), .cd_m(c_cdm), .cd_s(c_cds),
    .countdown_active(c_act), .return_req(c_req), .return_state(c_rs),
    .hurricane_avail(c_av), .uses_left(c_ul), .need_clean(c_nc), .display_data(c_disp));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk_1hz);
    #1;
  endtask

  task automatic do_reset();
    mode_state  = 3'd0;
    hand_clean  = 1'b0;
    menu_cancel = 1'b0;
    @(negedge clk_1hz);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    #1;
  endtask

  initial begin
    power_on = 1'b1;
    do_reset();
    chk("rst_cum_s", 32'(a_s), 32'd0);
    chk("rst_ret_req", 32'(a_req), 32'd0);
    chk("rst_ret_state", 32'(a_rs), 32'd0);
    chk("rst_need_clean", 32'(a_nc), 32'd0);
    chk("rst_uses_a", 32'(a_ul), 32'd1);
    chk("rst_uses_b", 32'(b_ul), 32'd2);
    chk("rst_avail", 32'(a_av), 32'd1);
    chk("rst_active", 32'(a_act), 32'd0);
    chk("rst_disp", a_disp, 32'h00F00F00);

    // Accumulator carry chain and hour saturation
    mode_state = 3'd1;
    step(3598);
    chk("sat_pre_m", 32'(c_m), 32'd59);
    chk("sat_pre_s", 32'(c_s), 32'd58);
    step(127);
    chk("acc_h", 32'(a_h), 32'd1);
    chk("acc_m", 32'(a_m), 32'd2);
    chk("acc_s", 32'(a_s), 32'd5);
    chk("acc_disp", a_disp, 32'h01F02F05);
    chk("sat_h", 32'(c_h), 32'd0);
    chk("sat_disp", c_disp, 32'h00F59F59);
    chk("sat_nc", 32'(c_nc), 32'd0);
    chk("acc_nc", 32'(a_nc), 32'd1);
    power_on = 1'b0;
    step(1);
    chk("pwroff_nc", 32'(a_nc), 32'd0);
    chk("pwroff_hold_s", 32'(a_s), 32'd5);
    power_on = 1'b1;

    // Clean threshold and manual clear
    do_reset();
    mode_state = 3'd2;
    step(10);
    chk("thr_s10", 32'(a_s), 32'd10);
    chk("thr_nc_e10", 32'(a_nc), 32'd0);
    mode_state = 3'd0;
    step(1);
    chk("thr_nc_e11", 32'(a_nc), 32'd1);
    hand_clean = 1'b1;
    step(1);
    chk("clr_s", 32'(a_s), 32'd0);
    chk("clr_nc_lag", 32'(a_nc), 32'd1);
    hand_clean = 1'b0;
    step(1);
    chk("clr_nc", 32'(a_nc), 32'd0);

    // Hurricane run to expiry, then lock-out
    do_reset();
    mode_state = 3'd3;
    step(1);
    chk("hur_load_s", 32'(a_cds), 32'd5);
    chk("hur_load_act", 32'(a_act), 32'd1);
    chk("hur_load_uses", 32'(a_ul), 32'd0);
    chk("hur_load_avail", 32'(a_av), 32'd0);
    chk("hur_load_disp", a_disp, 32'h00F00F05);
    step(4);
    chk("hur_s1", 32'(a_cds), 32'd1);
    step(1);
    chk("hur_s0", 32'(a_cds), 32'd0);
    chk("hur_s0_req", 32'(a_req), 32'd0);
    step(1);
    chk("hur_req", 32'(a_req), 32'd1);
    chk("hur_rs", 32'(a_rs), 32'd2);
    chk("hur_exp_act", 32'(a_act), 32'd0);
    step(1);
    chk("hur_req_drop", 32'(a_req), 32'd0);
    chk("hur_lock_avail", 32'(a_av), 32'd0);
    chk("hur_cum_s", 32'(a_s), 32'd8);
    mode_state = 3'd0;
    step(2);
    mode_state = 3'd3;
    step(3);
    chk("lock_act", 32'(a_act), 32'd0);
    chk("lock_req", 32'(a_req), 32'd0);
    chk("lock_cum_s", 32'(a_s), 32'd11);

    // Self-clean allowed from lock, returns to lock
    mode_state = 3'd4;
    step(1);
    chk("lsc_load_s", 32'(a_cds), 32'd3);
    chk("lsc_act", 32'(a_act), 32'd1);
    step(3);
    chk("lsc_s0", 32'(a_cds), 32'd0);
    step(1);
    chk("lsc_req", 32'(a_req), 32'd1);
    chk("lsc_rs", 32'(a_rs), 32'd0);
    chk("lsc_clr", 32'(a_s), 32'd0);
    mode_state = 3'd0;
    step(1);
    mode_state = 3'd3;
    step(1);
    chk("lsc_relock_avail", 32'(a_av), 32'd0);
    chk("lsc_relock_act", 32'(a_act), 32'd0);

    // Cancel during the run returns to standby
    do_reset();
    mode_state = 3'd3;
    step(3);
    chk("can_s3", 32'(a_cds), 32'd3);
    menu_cancel = 1'b1;
    step(1);
    menu_cancel = 1'b0;
    step(3);
    chk("can_req", 32'(a_req), 32'd1);
    chk("can_rs", 32'(a_rs), 32'd0);

    // Abort with a second use left, then a full second run
    do_reset();
    mode_state = 3'd3;
    step(2);
    chk("abt_s4", 32'(b_cds), 32'd4);
    chk("abt_uses1", 32'(b_ul), 32'd1);
    mode_state = 3'd2;
    step(1);
    chk("abt_act", 32'(b_act), 32'd0);
    chk("abt_cd0", 32'(b_cds), 32'd0);
    chk("abt_req", 32'(b_req), 32'd0);
    chk("abt_avail", 32'(b_av), 32'd1);
    chk("abt_uses", 32'(b_ul), 32'd1);
    step(2);
    chk("abt_req_late", 32'(b_req), 32'd0);
    mode_state = 3'd3;
    step(1);
    chk("run2_load", 32'(b_cds), 32'd5);
    chk("run2_uses", 32'(b_ul), 32'd0);
    step(6);
    chk("run2_req", 32'(b_req), 32'd1);
    chk("run2_rs", 32'(b_rs), 32'd2);
    step(1);
    mode_state = 3'd0;
    step(1);
    chk("run2_lock_avail", 32'(b_av), 32'd0);

    // Self-clean from idle clears the accumulator
    do_reset();
    mode_state = 3'd1;
    step(4);
    chk("sc_pre_s", 32'(a_s), 32'd4);
    mode_state = 3'd4;
    step(1);
    chk("sc_disp", a_disp, 32'h00F00F03);
    step(3);
    chk("sc_s0", 32'(a_cds), 32'd0);
    step(1);
    chk("sc_req", 32'(a_req), 32'd1);
    chk("sc_rs", 32'(a_rs), 32'd0);
    chk("sc_clr", 32'(a_s), 32'd0);
    mode_state = 3'd0;
    step(1);
    chk("sc_idle_avail", 32'(a_av), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hood_runtime_tracker.md
Name: hood_runtime_tracker

Overview:
Runtime and countdown engine for the range-hood controller, clocked at 1 Hz.
- Accumulates fan run time as HH:MM:SS and raises the clean reminder.
- Runs the hurricane and self-clean countdowns.
- Issues a one-cycle return request with the mode the top-level FSM must fall back to.

Generalises the earlier single-use, fixed-60 s tracker:
- parametrised durations, use count and clean threshold;
- hour saturation;
- an abort path;
- a self-clean countdown.

Parameters:
HURRICANE_SEC, 60, hurricane countdown length in seconds (1..5999)
SELF_CLEAN_SEC, 180, self-clean countdown length in seconds (1..5999)
HURRICANE_USES, 1, hurricane activations allowed per reset; 0 = unlimited
CLEAN_THRESH_SEC, 36000, accumulated run time at which need_clean asserts
MAX_HOURS, 99, hour saturation value (≤99)

Ports:
clk_1hz  in  1  1 Hz clock
rst  in  1  asynchronous, active-low reset
power_on  in  1  machine powered
mode_state  in  3  0 standby, 1 gear1, 2 gear2, 3 hurricane, 4 self-clean
hand_clean  in  1  manual clean done; level, held by upstream ≥1 s
menu_cancel  in  1  cancel hurricane to standby; level, held by upstream ≥1 s
cum_h  out  7  accumulated hours
cum_m  out  6  accumulated minutes
cum_s  out  6  accumulated seconds
cd_m  out  7  countdown minutes
cd_s  out  6  countdown seconds
countdown_active  out  1  hurricane or self-clean countdown running
return_req  out  1  one-cycle pulse: countdown expired
return_state  out  3  mode to enter on return_req
hurricane_avail  out  1  hurricane may start now
uses_left  out  8  remaining hurricane uses (HURRICANE_USES=0: reads 0, ignored)
need_clean  out  1  clean reminder
display_data  out  32  BCD digits hh F mm F ss, separators 4'hF

Behaviour:
Reset values:
- All counters 0; return_req 0; return_state 0; need_clean 0.
- uses_left = HURRICANE_USES.
- Countdown FSM in CD_IDLE.
- hurricane_avail = 1 when HURRICANE_USES≠0 or unlimited.
- Reset mid-countdown aborts it; no return_req is issued.

Accumulator:
- Increments on every edge with power_on=1 and mode_state ∈ {1,2,3}.
- Hurricane time counts even while locked.
- Carry chain: sec 59→0 carries to min; min 59→0 carries to hour.
- At MAX_HOURS:59:59 the counter holds (saturates, no wrap).
- Clear has priority over increment. Clear sources: hand_clean=1, or the self-clean expiry edge.

need_clean:
- Registered. Next value = power_on && (cum_h*3600+cum_m*60+cum_s ≥ CLEAN_THRESH_SEC), evaluated on current counter values.
- Drops one edge after the counters clear.

Countdown FSM states: CD_IDLE, CD_HURR, CD_CLEAN, CD_EXPIRE, CD_LOCKED.
- CD_IDLE, mode 3, hurricane_avail=1:
  - Load cd = HURRICANE_SEC as (N/60, N%60).
  - Decrement uses_left (unless unlimited).
  - Clear cancel_latched.
  - Go to CD_HURR.
- CD_IDLE, mode 4: load SELF_CLEAN_SEC, go to CD_CLEAN.
- CD_HURR / CD_CLEAN, each edge:
  - If cd≠0: decrement mm:ss (ss 0→59 with borrow from mm).
  - If cd==0: go to CD_EXPIRE.
- menu_cancel=1 in CD_HURR sets cancel_latched (sticky for that run).
- Mode changes away from 3 (in CD_HURR) or from 4 (in CD_CLEAN) before expiry:
  - Abort: cd←0, go to CD_IDLE, no return_req.
  - A consumed hurricane use is not refunded.
- CD_EXPIRE issues return_req=1 for exactly one edge, with return_state:
  - 0 if CD_CLEAN expired or cancel_latched=1;
  - otherwise 2.
  - Self-clean expiry also triggers the accumulator clear on this edge.
- CD_EXPIRE next state:
  - CD_LOCKED if uses_left==0 and the mode is limited;
  - otherwise CD_IDLE, entered only once mode_state≠3. A new run requires leaving mode 3 first.
- CD_LOCKED: hurricane requests are ignored; self-clean is still allowed from CD_LOCKED (returns to CD_LOCKED afterwards).
- hurricane_avail = (state==CD_IDLE) && (unlimited || uses_left≠0).
- countdown_active = state ∈ {CD_HURR, CD_CLEAN}.

Timing:
- Load edge shows N.
- Zero is reached N edges later.
- return_req is high on edge N+2 after the load edge (load, N decrements, expire).

display_data:
- Combinational from registers.
- Shows the countdown (hour digits 0) when countdown_active, otherwise the accumulator.
- Digits via /10 and %10.

Decomposition:
- Shared package hood_timer_pkg:
  - mode codes MODE_STANDBY..MODE_SELFCLEAN;
  - SEP_DIGIT=4'hF;
  - countdown state enum.
- One sub-module, mmss_down_counter:
  - ports: load, load_val, enable;
  - outputs: mm, ss, zero.
  - Instantiated once, shared by hurricane and self-clean.

Test Plan:
- Reset; mode 1 for 3725 edges → cum 01:02:05, display_data 32'h01F02F05.
- CLEAN_THRESH_SEC=10, mode 2 for 10 edges → need_clean=1 on edge 11; hand_clean for 1 edge → counters 0, need_clean=0 on the next edge.
- HURRICANE_SEC=5, USES=1, mode 3 held → cd 0:05…0:00, return_req pulse on edge 7 with return_state=2, then CD_LOCKED, hurricane_avail=0; a re-entry of mode 3 starts no countdown.
- Same setup, menu_cancel at cd=0:03 → return_req with return_state=0.
- USES=2, mode 3 for 2 edges then mode 2 → abort with no return_req, uses_left=1, hurricane_avail=1; second run completes, then locked.
- MAX_HOURS=0, preload to 00:59:58, mode 1 for 5 edges → holds 00:59:59. Separately, mode 4 with SELF_CLEAN_SEC=3 → return_req with return_state=0 and counters cleared.
